uart_tx_ctrl: RTL and testbench
===============================

# uart_tx_ctrl

UART transmit controller that sequences one serial frame per accepted byte on the bit-rate clock. It owns the frame state machine, the data serializer and the output bit select. It drives the existing parity generator through its enable and type inputs, and consumes that generator's registered parity bit. It sits between the system-side byte source (register file or FIFO read side) and the TX pin.

## Interface
- DATA_WIDTH, 8, payload bits per frame.
- CLK  in  1  bit-rate clock (one serial bit per cycle).
- RST  in  1  reset; one clock; reset is asynchronous and active-low.
- P_DATA  in  DATA_WIDTH  byte to send; sampled on accept.
- DATA_Valid  in  1  byte available. Also fans out to the parity generator's DATA_Valid.
- PAR_EN  in  1  frame carries a parity bit; sampled on accept.
- PAR_TYP  in  1  0 = even-parity bit (^data), 1 = odd-parity bit (~^data); sampled on accept.
- par_bit  in  1  registered parity bit from the parity generator.
- par_calc_en  out  1  drives the parity generator's parity_enable.
- par_typ_o  out  1  registered PAR_TYP; drives the parity generator's PAR_TYP.
- TX_OUT  out  1  serial line, registered; idle high.
- Busy  out  1  frame in progress, registered.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - TX_OUT = 1, Busy = 0.
  - Accept when DATA_Valid = 1. On accept: latch P_DATA into the shift register, latch PAR_EN into par_en_q, latch PAR_TYP into par_typ_o, then go to START.
- START:
  - TX_OUT = 0, Busy = 1.
  - par_calc_en = 1 for exactly this one cycle. par_bit is then valid from the next edge.
  - Go to DATA with bit counter = 0.
- DATA:
  - TX_OUT = shift register LSB, sent LSB first.
  - Shift right and increment the counter each cycle.
  - After bit DATA_WIDTH-1: go to PARITY if par_en_q = 1, else go to STOP.
- PARITY: TX_OUT = par_bit, then go to STOP.
- STOP: TX_OUT = 1, Busy = 1, then go to IDLE.
- Outside START, par_calc_en = 0, so par_bit holds its value.
- While Busy, DATA_Valid is ignored: no queueing and no error flag. Note that the parity generator still relatches its data input on DATA_Valid. Sources must not assert DATA_Valid while Busy = 1.
- Only IDLE accepts a byte, so consecutive frames are separated by at least one idle-high cycle.
- Counter width is clog2(DATA_WIDTH) and the counter never wraps within a frame.
- Illegal state encodings return to IDLE.

## Timing
- Reset values: TX_OUT = 1, Busy = 0, par_calc_en = 0, par_typ_o = 0, state IDLE, shift register 0, counter 0.
- Accept edge E0: TX_OUT = 0 and Busy = 1 appear after E0.
- Edge timeline:
  - E0: start bit begins.
  - E1 to E(DATA_WIDTH): data bits.
  - E(DATA_WIDTH+1): parity bit, when enabled.
  - Next edge: stop bit.
  - Following edge: TX_OUT = 1 idle, Busy = 0.
- Frame length: DATA_WIDTH+3 cycles with parity (11 for the default width), DATA_WIDTH+2 without (10).
- TX_OUT and Busy have no combinational path from inputs.
- par_calc_en is a decode of the state register only.
- Asynchronous reset mid-frame: TX_OUT returns to 1 and Busy to 0 immediately, and the partial frame is abandoned. The first accept after reset release starts a fresh frame.

## Structure
- Package uart_tx_pkg:
  - State enum: IDLE, START, DATA, PARITY, STOP.
  - START_BIT = 1'b0, STOP_BIT = 1'b1, IDLE_LEVEL = 1'b1.
- Sub-module uart_tx_serializer:
  - Shift register plus bit counter.
  - Inputs: load, shift_en.
  - Outputs: ser_data, ser_done, with ser_done asserted on the last data bit.
- The FSM and output mux stay in uart_tx_ctrl.
- The parity generator is instantiated beside uart_tx_ctrl at the top level, not inside it.

## Test plan
- P_DATA = 0xA5, PAR_EN = 1, PAR_TYP = 0, 1-cycle DATA_Valid (bench includes the parity generator) -> TX_OUT = 0,1,0,1,0,0,1,0,1,0,1, then idle 1. Busy high for 11 cycles.
- P_DATA = 0x07, PAR_EN = 1, PAR_TYP = 0 -> parity slot = 1. Repeat with PAR_TYP = 1 -> parity slot = 0.
- P_DATA = 0x3C, PAR_EN = 0 -> TX_OUT = 0,0,0,1,1,1,1,0,0,1. Busy high for 10 cycles. par_calc_en pulses once.
- DATA_Valid held high for 30 cycles with fixed data -> frames separated by exactly one idle-high cycle. PAR_TYP toggled mid-frame does not change the current parity slot.
- Assert RST during data bit 4 -> TX_OUT = 1 and Busy = 0 asynchronously. After release, a new 0x55 frame is sent correctly.
- Randomised bytes and configs with a reference serializer scoreboard; check frame length, bit order and parity on every frame.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// Shared types and line levels for the UART transmit controller and its serializer.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_tx_serializer.sv
// Payload shift register and bit counter; ser_data is the next payload bit to put on the line.
module uart_tx_serializer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  shift_en,
  output logic                  ser_data,
  output logic                  ser_done
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  first_q, first_d;

  // The first shift hands bit 0 to the line register while the start bit is still
  // showing, so it must not advance the counter; cnt_q then tracks the bit on the line.
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    if (load) begin
      shift_d = load_data;
      cnt_d   = '0;
      first_d = 1'b1;
    end else if (shift_en) begin
      shift_d = shift_q >> 1;
      first_d = 1'b0;
      if (!first_q) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      cnt_q   <= '0;
      first_q <= 1'b0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
    end
  end

  assign ser_data = shift_q[0];
  assign ser_done = !first_q && (cnt_q == LAST_IDX);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: start, LSB-first payload, optional parity, stop.
// Parity comes from an external generator driven through par_calc_en / par_typ_o.
module uart_tx_ctrl
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  par_bit,
  output logic                  par_calc_en,
  output logic                  par_typ_o,
  output logic                  TX_OUT,
  output logic                  Busy
);

  tx_state_e state_q, state_d;
  logic      tx_out_q, tx_out_d;
  logic      busy_q, busy_d;
  logic      par_en_q, par_en_d;
  logic      par_typ_q, par_typ_d;
  logic      load, shift_en;
  logic      ser_data, ser_done;

  uart_tx_serializer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_serializer (
    .clk      (CLK),
    .rst_n    (RST),
    .load     (load),
    .load_data(P_DATA),
    .shift_en (shift_en),
    .ser_data (ser_data),
    .ser_done (ser_done)
  );

  // Line level and Busy are decided one cycle ahead so they leave straight from flops.
  always_comb begin
    state_d   = state_q;
    tx_out_d  = tx_out_q;
    busy_d    = busy_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    load      = 1'b0;
    shift_en  = 1'b0;
    case (state_q)
      IDLE: begin
        tx_out_d = IDLE_LEVEL;
        busy_d   = 1'b0;
        if (DATA_Valid) begin
          load      = 1'b1;
          par_en_d  = PAR_EN;
          par_typ_d = PAR_TYP;
          tx_out_d  = START_BIT;
          busy_d    = 1'b1;
          state_d   = START;
        end
      end
      START: begin
        tx_out_d = ser_data;
        shift_en = 1'b1;
        state_d  = DATA;
      end
      DATA: begin
        if (ser_done) begin
          if (par_en_q) begin
            tx_out_d = par_bit;
            state_d  = PARITY;
          end else begin
            tx_out_d = STOP_BIT;
            state_d  = STOP;
          end
        end else begin
          tx_out_d = ser_data;
          shift_en = 1'b1;
        end
      end
      PARITY: begin
        tx_out_d = STOP_BIT;
        state_d  = STOP;
      end
      STOP: begin
        tx_out_d = IDLE_LEVEL;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
      default: begin
        tx_out_d = IDLE_LEVEL;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      tx_out_q  <= IDLE_LEVEL;
      busy_q    <= 1'b0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_out_q  <= tx_out_d;
      busy_q    <= busy_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
    end
  end

  assign par_calc_en = (state_q == START);
  assign par_typ_o   = par_typ_q;
  assign TX_OUT      = tx_out_q;
  assign Busy        = busy_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl with a behavioural parity generator beside it.
// Inputs change and outputs are sampled on the falling edge of the bit clock.
module tb_uart_tx_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] p_data;
  logic       data_valid;
  logic       par_en;
  logic       par_typ;
  logic       par_bit;
  logic       par_calc_en;
  logic       par_typ_o;
  logic       tx_out;
  logic       busy;
  logic [7:0] pg_data;

  int error_count = 0;
  int check_count = 0;

  always #5 clk = ~clk;

  uart_tx_ctrl #(.DATA_WIDTH(8)) dut (
    .CLK        (clk),
    .RST        (rst_n),
    .P_DATA     (p_data),
    .DATA_Valid (data_valid),
    .PAR_EN     (par_en),
    .PAR_TYP    (par_typ),
    .par_bit    (par_bit),
    .par_calc_en(par_calc_en),
    .par_typ_o  (par_typ_o),
    .TX_OUT     (tx_out),
    .Busy       (busy)
  );

  // Parity generator as it sits at the system top: latches data on DATA_Valid,
  // computes the registered parity bit when enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pg_data <= '0;
      par_bit <= 1'b0;
    end else begin
      if (data_valid) pg_data <= p_data;
      if (par_calc_en) par_bit <= par_typ_o ? ~^pg_data : ^pg_data;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Reference frame: the line levels from the start bit through the stop bit.
  function automatic void frameBits(input logic [7:0] data, input logic pen, input logic ptyp,
                                    output logic bits[$]);
    bits.delete();
    bits.push_back(1'b0);
    for (int b = 0; b < 8; b++) bits.push_back(data[b]);
    if (pen) bits.push_back(ptyp ? ~^data : ^data);
    bits.push_back(1'b1);
  endfunction

  // Sends one frame from idle and checks every cycle of it plus gap idle cycles after.
  // Called just after a falling edge; returns just after a falling edge.
  task automatic applyStimulus(input logic [7:0] data, input logic pen, input logic ptyp, input int gap);
    logic exp_bits[$];
    int   len;
    frameBits(data, pen, ptyp, exp_bits);
    len = exp_bits.size();
    p_data     = data;
    par_en     = pen;
    par_typ    = ptyp;
    data_valid = 1'b1;
    for (int i = 0; i <= len + gap; i++) begin
      @(negedge clk);
      checkOutput("tx_bit",  {31'b0, tx_out},      {31'b0, (i < len) ? exp_bits[i] : 1'b1});
      checkOutput("busy",    {31'b0, busy},        {31'b0, (i < len)});
      checkOutput("pce",     {31'b0, par_calc_en}, {31'b0, (i == 0)});
      if (i < len) checkOutput("par_typ_o", {31'b0, par_typ_o}, {31'b0, ptyp});
      data_valid = 1'b0;
      p_data     = 8'($urandom);
      par_typ    = 1'($urandom);
      par_en     = 1'($urandom);
    end
  endtask

  initial begin
    logic exp_bits[$];
    int   idx;
    rst_n      = 1'b0;
    p_data     = '0;
    data_valid = 1'b0;
    par_en     = 1'b0;
    par_typ    = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_tx",   {31'b0, tx_out},      32'd1);
    checkOutput("rst_busy", {31'b0, busy},        32'd0);
    checkOutput("rst_pce",  {31'b0, par_calc_en}, 32'd0);
    checkOutput("rst_ptyp", {31'b0, par_typ_o},   32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("idle_tx",   {31'b0, tx_out}, 32'd1);
    checkOutput("idle_busy", {31'b0, busy},   32'd0);

    applyStimulus(8'hA5, 1'b1, 1'b0, 1);
    applyStimulus(8'h07, 1'b1, 1'b0, 0);
    applyStimulus(8'h07, 1'b1, 1'b1, 0);
    applyStimulus(8'h3C, 1'b0, 1'b0, 2);

    // DATA_Valid held for 30 edges; PAR_TYP pulses high mid-frame but is low at each accept.
    frameBits(8'h0B, 1'b1, 1'b0, exp_bits);
    p_data     = 8'h0B;
    par_en     = 1'b1;
    par_typ    = 1'b0;
    data_valid = 1'b1;
    for (int k = 0; k < 36; k++) begin
      @(negedge clk);
      idx = k % 12;
      checkOutput("held_tx",   {31'b0, tx_out}, {31'b0, (idx < 11) ? exp_bits[idx] : 1'b1});
      checkOutput("held_busy", {31'b0, busy},   {31'b0, (idx < 11)});
      checkOutput("held_ptyp", {31'b0, par_typ_o}, 32'd0);
      data_valid = (k + 1 <= 29);
      par_typ    = (((k + 1) % 12) >= 3) && (((k + 1) % 12) <= 8);
    end
    data_valid = 1'b0;
    par_typ    = 1'b0;
    @(negedge clk);

    // Asynchronous reset while data bit 4 is on the line.
    frameBits(8'hA5, 1'b1, 1'b0, exp_bits);
    p_data     = 8'hA5;
    par_en     = 1'b1;
    par_typ    = 1'b0;
    data_valid = 1'b1;
    for (int i = 0; i <= 5; i++) begin
      @(negedge clk);
      data_valid = 1'b0;
      checkOutput("pre_rst_tx", {31'b0, tx_out}, {31'b0, exp_bits[i]});
    end
    rst_n = 1'b0;
    #1;
    checkOutput("async_tx",   {31'b0, tx_out},      32'd1);
    checkOutput("async_busy", {31'b0, busy},        32'd0);
    checkOutput("async_pce",  {31'b0, par_calc_en}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(8'h55, 1'b1, 1'b0, 1);

    for (int n = 0; n < 40; n++) begin
      applyStimulus(8'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end

endmodule
